pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and branch-resolution stage of the 9-bit RISC CPU. It sits downstream of the ALU, consumes the ALU zero flag `z` for BNE resolution and upstream of instruction memory, drives the fetch address each cycle. Branch targets are absolute addresses held in an internal, software-loadable lookup table indexed by a field of the branch instruction. A small run/halt state machine controls program start and completion and counts executed cycles.

## Interface
- `PC_W`, 10: width of PC / instruction address.
- `LUT_AW`, 5: branch-target LUT address width (2^LUT_AW entries of `PC_W` bits).
- `CNT_W`, 16: width of executed-cycle counter.

- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  pulse: begin execution at `start_addr`.
- `start_addr`  in  PC_W  first instruction address.
- `stall`  in  1  hold PC this cycle (multi-cycle memory op).
- `branch_en`  in  1  decoded current instruction is BNE.
- `z`  in  1  ALU zero flag for current instruction (1 = operands equal).
- `target_idx`  in  LUT_AW  LUT index from current BNE instruction.
- `halt`  in  1  decoded current instruction is HALT.
- `lut_we`  in  1  LUT write enable.
- `lut_waddr`  in  LUT_AW  LUT write index.
- `lut_wdata`  in  PC_W  LUT write data (absolute target).
- `pc`  out  PC_W  current fetch address (registered).
- `running`  out  1  high in RUN state.
- `done`  out  1  high in HALTED state.
- `cycle_cnt`  out  CNT_W  RUN cycles since last start, saturating.

## Operation
- States: IDLE, RUN, HALTED. Reset → IDLE.
- IDLE: `pc` holds; `start` → RUN, `pc` ← `start_addr`, `cycle_cnt` ← 0.
- RUN, per cycle, priority highest first:
  - `stall`=1: `pc` holds; `branch_en`/`halt` ignored; `cycle_cnt` still increments.
  - `halt`=1: → HALTED; `pc` holds (points at HALT).
  - `branch_en`=1 and `z`=0 (not equal): `pc` ← LUT[`target_idx`].
  - otherwise (incl. `branch_en`=1, `z`=1): `pc` ← `pc`+1, modulo 2^PC_W (max address wraps to 0).
  - `start` ignored in RUN.
- HALTED: `pc`, `cycle_cnt` hold; `done`=1; `start` → RUN exactly as from IDLE.
- `cycle_cnt`: increments once per RUN cycle (including the HALT cycle itself, since it is a RUN cycle); saturates at 2^CNT_W−1, never wraps.
- LUT: 2^LUT_AW × PC_W registers, writable in any state when `lut_we`=1. Read is combinational from current contents; write to the entry being read in the same cycle: branch uses old value, new value visible next cycle.
- All inputs other than `start`/LUT port are don't-care outside RUN.

## Timing
- Reset values: `pc`=0, `running`=0, `done`=0, `cycle_cnt`=0, all LUT entries 0, state IDLE. Reset asserted mid-RUN aborts immediately (async); outputs return to reset values without waiting for a clock edge.
- `start` sampled at edge k → at k: `pc`=`start_addr`, `running`=1.
- Branch/increment decision uses `branch_en`, `z`, `target_idx`, `halt`, `stall` sampled at edge k; next `pc` visible after edge k (one-cycle latency, no delay slot).
- `halt` at edge k → `done`=1, `running`=0 after edge k; `pc` unchanged.
- `running` and `done` never both 1; both 0 only in IDLE.

## Test plan
- Reset mid-RUN with `pc`=0x05A, `cycle_cnt`=7: assert `reset` between edges → `pc`=0, `running`=0, `done`=0, `cycle_cnt`=0 immediately; LUT[3] reads 0 afterward.
- `start` with `start_addr`=0x010, no branches, 4 cycles → `pc` sequence 0x010, 0x011, 0x012, 0x013, 0x014; `cycle_cnt`=4. Start at 0x3FF → next `pc`=0x000 (wrap).
- Load LUT[3]=0x120; at `pc`=0x020 present `branch_en`=1, `target_idx`=3, `z`=0 → next `pc`=0x120; repeat with `z`=1 → next `pc`=0x021.
- Same cycle `lut_we`=1, `lut_waddr`=3, `lut_wdata`=0x200 and taken branch via idx 3 (old 0x120) → `pc`=0x120; next taken branch via idx 3 → `pc`=0x200.
- `stall`=1 with `halt`=1 and `branch_en`=1,`z`=0 at `pc`=0x030 → `pc` stays 0x030, still RUN; next cycle `halt`=1 with `branch_en`=1,`z`=0 → HALTED, `done`=1, `pc`=0x030.
- From HALTED, `start` with `start_addr`=0x000 → RUN, `pc`=0, `cycle_cnt`=0; `start` during RUN at `pc`=0x005 → ignored, `pc`=0x006. With `CNT_W`=4, run 20 cycles → `cycle_cnt`=15.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter and branch-resolution stage of the 9-bit RISC CPU.
// Run/halt control, absolute-target BNE resolution through a loadable LUT, and a saturating run-cycle counter.
module pc_fetch_unit #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PC_W-1:0]   start_addr,
    input  logic              stall,
    input  logic              branch_en,
    input  logic              z,
    input  logic [LUT_AW-1:0] target_idx,
    input  logic              halt,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [PC_W-1:0]   lut_wdata,
    output logic [PC_W-1:0]   pc,
    output logic              running,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam int LUT_N = 1 << LUT_AW;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   lut_q [LUT_N];
    logic [PC_W-1:0]   lut_rdata;

    // Combinational read of the current contents: a same-cycle write is seen only from the next cycle.
    assign lut_rdata = lut_q[target_idx];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = start_addr;
                    cnt_d   = '0;
                end
            end

            S_RUN: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end

                if (stall) begin
                    pc_d = pc_q;
                end else if (halt) begin
                    state_d = S_HALTED;
                end else if (branch_en && !z) begin
                    pc_d = lut_rdata;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of process order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the target table must read as zero after reset, so it is built from resettable flops rather than a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LUT_N; i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_we) begin
            lut_q[lut_waddr] <= lut_wdata;
        end
    end

    assign pc        = pc_q;
    assign running   = (state_q == S_RUN);
    assign done      = (state_q == S_HALTED);
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed stimulus pushes expected post-edge state, a monitor pops and compares.
// A second instance with a 4-bit counter exercises counter saturation.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start4;
    logic [9:0]  start_addr;
    logic        stall, branch_en, z, halt;
    logic [4:0]  target_idx;
    logic        lut_we;
    logic [4:0]  lut_waddr;
    logic [9:0]  lut_wdata;

    logic [9:0]  pc, pc4;
    logic        running, done, running4, done4;
    logic [15:0] cycle_cnt;
    logic [3:0]  cycle_cnt4;

    always #5 clk = ~clk;

    pc_fetch_unit #(.PC_W(10), .LUT_AW(5), .CNT_W(16)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .stall      (stall),
        .branch_en  (branch_en),
        .z          (z),
        .target_idx (target_idx),
        .halt       (halt),
        .lut_we     (lut_we),
        .lut_waddr  (lut_waddr),
        .lut_wdata  (lut_wdata),
        .pc         (pc),
        .running    (running),
        .done       (done),
        .cycle_cnt  (cycle_cnt)
    );

    pc_fetch_unit #(.PC_W(10), .LUT_AW(5), .CNT_W(4)) u_dut4 (
        .clk        (clk),
        .reset      (reset),
        .start      (start4),
        .start_addr (start_addr),
        .stall      (1'b0),
        .branch_en  (1'b0),
        .z          (1'b0),
        .target_idx (5'd0),
        .halt       (1'b0),
        .lut_we     (1'b0),
        .lut_waddr  (5'd0),
        .lut_wdata  (10'd0),
        .pc         (pc4),
        .running    (running4),
        .done       (done4),
        .cycle_cnt  (cycle_cnt4)
    );

    typedef struct {
        string       name;
        bit          dut4;
        logic [9:0]  pc;
        logic        running;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    event sample_ev;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        -> sample_ev;
    end

    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.dut4) begin
                    check({e.name, ".pc"},      32'(pc4),        32'(e.pc));
                    check({e.name, ".running"}, 32'(running4),   32'(e.running));
                    check({e.name, ".done"},    32'(done4),      32'(e.done));
                    check({e.name, ".cnt"},     32'(cycle_cnt4), 32'(e.cnt));
                end else begin
                    check({e.name, ".pc"},      32'(pc),         32'(e.pc));
                    check({e.name, ".running"}, 32'(running),    32'(e.running));
                    check({e.name, ".done"},    32'(done),       32'(e.done));
                    check({e.name, ".cnt"},     32'(cycle_cnt),  32'(e.cnt));
                    check({e.name, ".excl"},    32'(running & done), 32'(0));
                end
            end
        end
    end

    task automatic push_exp(input string nm, input bit d4, input logic [9:0] p,
                            input logic r, input logic d, input logic [15:0] c);
        exp_t e;
        e.name    = nm;
        e.dut4    = d4;
        e.pc      = p;
        e.running = r;
        e.done    = d;
        e.cnt     = c;
        exp_q.push_back(e);
    endtask

    // Issue the inputs currently driven for one edge, expect the given post-edge state, then clear pulses.
    task automatic cyc(input string nm, input bit d4, input logic [9:0] p,
                       input logic r, input logic d, input logic [15:0] c);
        push_exp(nm, d4, p, r, d, c);
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        start4    = 1'b0;
        stall     = 1'b0;
        branch_en = 1'b0;
        z         = 1'b0;
        halt      = 1'b0;
        lut_we    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        start4     = 1'b0;
        start_addr = '0;
        stall      = 1'b0;
        branch_en  = 1'b0;
        z          = 1'b0;
        target_idx = '0;
        halt       = 1'b0;
        lut_we     = 1'b0;
        lut_waddr  = '0;
        lut_wdata  = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        cyc("reset_idle", 0, 10'h000, 0, 0, 16'd0);

        // Sequential fetch from 0x010
        start = 1'b1; start_addr = 10'h010;
        cyc("start_010", 0, 10'h010, 1, 0, 16'd0);
        for (int i = 1; i <= 4; i++) begin
            cyc($sformatf("inc%0d", i), 0, 10'(10'h010 + i), 1, 0, 16'(i));
        end
        halt = 1'b1;
        cyc("halt_a", 0, 10'h014, 0, 1, 16'd5);

        // Wrap at top of address space
        start = 1'b1; start_addr = 10'h3FF;
        cyc("start_3ff", 0, 10'h3FF, 1, 0, 16'd0);
        cyc("wrap", 0, 10'h000, 1, 0, 16'd1);

        // LUT load while running, then taken / not-taken BNE from 0x020
        lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 10'h120;
        cyc("lut_load", 0, 10'h001, 1, 0, 16'd2);
        halt = 1'b1;
        cyc("halt_b", 0, 10'h001, 0, 1, 16'd3);
        start = 1'b1; start_addr = 10'h020;
        cyc("start_020a", 0, 10'h020, 1, 0, 16'd0);
        branch_en = 1'b1; target_idx = 5'd3; z = 1'b0;
        cyc("bne_taken", 0, 10'h120, 1, 0, 16'd1);
        halt = 1'b1;
        cyc("halt_c", 0, 10'h120, 0, 1, 16'd2);
        start = 1'b1; start_addr = 10'h020;
        cyc("start_020b", 0, 10'h020, 1, 0, 16'd0);
        branch_en = 1'b1; target_idx = 5'd3; z = 1'b1;
        cyc("bne_not_taken", 0, 10'h021, 1, 0, 16'd1);

        // Write and read the same entry in one cycle: old target used
        lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 10'h200;
        branch_en = 1'b1; target_idx = 5'd3; z = 1'b0;
        cyc("wr_rd_same", 0, 10'h120, 1, 0, 16'd2);
        branch_en = 1'b1; target_idx = 5'd3; z = 1'b0;
        cyc("new_target", 0, 10'h200, 1, 0, 16'd3);

        // Stall over halt and branch, then halt over branch
        halt = 1'b1;
        cyc("halt_d", 0, 10'h200, 0, 1, 16'd4);
        start = 1'b1; start_addr = 10'h030;
        cyc("start_030", 0, 10'h030, 1, 0, 16'd0);
        stall = 1'b1; halt = 1'b1; branch_en = 1'b1; target_idx = 5'd3; z = 1'b0;
        cyc("stall_prio", 0, 10'h030, 1, 0, 16'd1);
        halt = 1'b1; branch_en = 1'b1; target_idx = 5'd3; z = 1'b0;
        cyc("halt_over_br", 0, 10'h030, 0, 1, 16'd2);
        branch_en = 1'b1; target_idx = 5'd3; z = 1'b0;
        cyc("halted_hold", 0, 10'h030, 0, 1, 16'd2);

        // Restart from HALTED, then start ignored while running
        start = 1'b1; start_addr = 10'h000;
        cyc("restart_000", 0, 10'h000, 1, 0, 16'd0);
        for (int i = 1; i <= 5; i++) begin
            cyc($sformatf("run%0d", i), 0, 10'(i), 1, 0, 16'(i));
        end
        start = 1'b1; start_addr = 10'h3AB;
        cyc("start_in_run", 0, 10'h006, 1, 0, 16'd6);

        // Reach pc=0x05A, cycle_cnt=7, then reset between edges
        halt = 1'b1;
        cyc("halt_e", 0, 10'h006, 0, 1, 16'd7);
        start = 1'b1; start_addr = 10'h053;
        cyc("start_053", 0, 10'h053, 1, 0, 16'd0);
        for (int i = 1; i <= 7; i++) begin
            cyc($sformatf("pre_rst%0d", i), 0, 10'(10'h053 + i), 1, 0, 16'(i));
        end
        #2;
        reset = 1'b1;
        #1;
        push_exp("async_reset", 0, 10'h000, 0, 0, 16'd0);
        -> sample_ev;
        @(negedge clk);
        reset = 1'b0;

        // LUT entry 3 must be back to zero
        start = 1'b1; start_addr = 10'h040;
        cyc("start_040", 0, 10'h040, 1, 0, 16'd0);
        branch_en = 1'b1; target_idx = 5'd3; z = 1'b0;
        cyc("lut_cleared", 0, 10'h000, 1, 0, 16'd1);

        // 4-bit counter saturates at 15
        start4 = 1'b1; start_addr = 10'h100;
        cyc("d4_start", 1, 10'h100, 1, 0, 16'd0);
        for (int i = 1; i <= 20; i++) begin
            cyc($sformatf("d4_run%0d", i), 1, 10'(10'h100 + i), 1, 0, 16'((i > 15) ? 15 : i));
        end

        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
